mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 162 ++++++++++++++++
 tb/tb_mem_responder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// ============================================================================
// Module   : mem_responder
// Brief    : Single-port memory responder with an instruction bank
//            (write-protected) and a data bank. Reads are returned after a
//            programmable latency; bad requests get a one-cycle error pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int DEPTH_WORDS  = 64,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  memReq,
    input  logic                  memRead,
    input  logic                  memSelect,
    input  logic [ADDR_WIDTH-1:0] memAddr,
    input  logic [DATA_WIDTH-1:0] memWData,
    output logic                  memReady,
    output logic [DATA_WIDTH-1:0] memRData,
    output logic                  memRValid,
    output logic                  memWAck,
    output logic                  memError
);

    localparam int IDX_BITS  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int WORD_BITS = ADDR_WIDTH - 2;
    localparam logic [WORD_BITS:0] DEPTH_LIMIT = (WORD_BITS + 1)'(DEPTH_WORDS);
    localparam logic [3:0] LAT_LOAD = 4'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READ_WAIT = 3'd1,
        WRITE     = 3'd2,
        RESPOND   = 3'd3,
        ERROR     = 3'd4
    } state_t;

    state_t state;
    state_t next_state;
    logic [3:0] lat_cnt;
    logic [3:0] next_cnt;

    // Request captured at acceptance
    logic                  req_sel;
    logic [IDX_BITS-1:0]   req_index;
    logic [DATA_WIDTH-1:0] req_wdata;

    // Bank 0 = instruction (never written), bank 1 = data. Not reset.
    logic [DATA_WIDTH-1:0] bank [0:1][0:DEPTH_WORDS-1];

    logic [WORD_BITS-1:0] word_index;
    logic misaligned;
    logic out_of_range;
    logic write_protect;
    logic reject;
    logic accept;

    assign word_index    = memAddr[ADDR_WIDTH-1:2];
    assign misaligned    = |memAddr[1:0];
    assign out_of_range  = ({1'b0, word_index} >= DEPTH_LIMIT);
    assign write_protect = !memRead && !memSelect;
    assign reject        = misaligned || out_of_range || write_protect;
    assign accept        = (state == IDLE) && memReq;
    assign memReady      = (state == IDLE);

    // State register and latency counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            lat_cnt <= 4'd0;
        end else begin
            state   <= next_state;
            lat_cnt <= next_cnt;
        end
    end

    // Next-state and counter logic
    always_comb begin
        next_state = state;
        next_cnt   = lat_cnt;
        case (state)
            IDLE: begin
                if (memReq) begin
                    if (reject) begin
                        next_state = ERROR;
                    end else if (memRead) begin
                        if (READ_LATENCY == 1) begin
                            next_state = RESPOND;
                            next_cnt   = 4'd0;
                        end else begin
                            next_state = READ_WAIT;
                            next_cnt   = LAT_LOAD;
                        end
                    end else begin
                        next_state = WRITE;
                    end
                end
            end
            READ_WAIT: begin
                // RESPOND is entered on the edge where the counter reaches zero
                if (lat_cnt <= 4'd1) begin
                    next_state = RESPOND;
                    next_cnt   = 4'd0;
                end else begin
                    next_cnt = lat_cnt - 4'd1;
                end
            end
            WRITE:   next_state = IDLE;
            RESPOND: next_state = IDLE;
            ERROR:   next_state = IDLE;
            default: begin
                next_state = IDLE;
                next_cnt   = 4'd0;
            end
        endcase
    end

    // Capture the request fields on the accepting edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_sel   <= 1'b0;
            req_index <= '0;
            req_wdata <= '0;
        end else if (accept) begin
            req_sel   <= memSelect;
            req_index <= memAddr[IDX_BITS+1:2];
            req_wdata <= memWData;
        end
    end

    // Registered response pulses; the read word is fetched in RESPOND and
    // presented with memRValid on the following cycle, keeping memRData zero
    // otherwise.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            memRValid <= 1'b0;
            memRData  <= '0;
            memWAck   <= 1'b0;
            memError  <= 1'b0;
        end else begin
            memRValid <= (state == RESPOND);
            memRData  <= (state == RESPOND) ? bank[req_sel][req_index] : '0;
            memWAck   <= (next_state == WRITE);
            memError  <= (next_state == ERROR);
        end
    end

    // Data-bank write commits on the edge that leaves WRITE
    always_ff @(posedge clock) begin
        if (state == WRITE) begin
            bank[1][req_index] <= req_wdata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// Module   : tb_mem_responder
// Brief    : Directed, table-driven bench for mem_responder at read
//            latencies 2, 1 and 15 (ADDR_WIDTH=9, DEPTH_WORDS=64).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  req   = 3'b000;
    logic        rd    = 1'b0;
    logic        sel   = 1'b0;
    logic [8:0]  addr  = '0;
    logic [31:0] wdata = '0;

    logic [2:0]  ready;
    logic [2:0]  rvalid;
    logic [2:0]  wack;
    logic [2:0]  err;
    logic [31:0] rdata [3];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .DEPTH_WORDS(64), .READ_LATENCY(2)) dut_l2 (
        .clock(clock), .reset(reset), .memReq(req[0]), .memRead(rd), .memSelect(sel),
        .memAddr(addr), .memWData(wdata), .memReady(ready[0]), .memRData(rdata[0]),
        .memRValid(rvalid[0]), .memWAck(wack[0]), .memError(err[0]));

    mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .DEPTH_WORDS(64), .READ_LATENCY(1)) dut_l1 (
        .clock(clock), .reset(reset), .memReq(req[1]), .memRead(rd), .memSelect(sel),
        .memAddr(addr), .memWData(wdata), .memReady(ready[1]), .memRData(rdata[1]),
        .memRValid(rvalid[1]), .memWAck(wack[1]), .memError(err[1]));

    mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .DEPTH_WORDS(64), .READ_LATENCY(15)) dut_l15 (
        .clock(clock), .reset(reset), .memReq(req[2]), .memRead(rd), .memSelect(sel),
        .memAddr(addr), .memWData(wdata), .memReady(ready[2]), .memRData(rdata[2]),
        .memRValid(rvalid[2]), .memWAck(wack[2]), .memError(err[2]));

    // kind: 0 none, 1 rvalid, 2 wack, 3 error
    typedef struct {
        int          dut;
        bit          rd;
        bit          sel;
        logic [8:0]  addr;
        logic [31:0] wdata;
        int          exp_kind;
        int          exp_lat;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [17];

    function automatic vec_t mk(int d, bit r, bit s, logic [8:0] a, logic [31:0] w,
                                int k, int l, logic [31:0] x);
        vec_t v;
        v.dut = d; v.rd = r; v.sel = s; v.addr = a; v.wdata = w;
        v.exp_kind = k; v.exp_lat = l; v.exp_data = x;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one request to DUT k, then watch 20 cycles. lat is the cycle index
    // of the first pulse, where 0 is the cycle following the accepting edge.
    task automatic run_op(input int k, input bit r, input bit s, input logic [8:0] a,
                          input logic [31:0] d, output int kind, output int lat,
                          output logic [31:0] data, output int pulses, output int zero_viol);
        @(negedge clock);
        rd = r; sel = s; addr = a; wdata = d; req[k] = 1'b1;
        @(posedge clock);
        #1 req[k] = 1'b0;
        kind = 0; lat = -1; data = '0; pulses = 0; zero_viol = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clock);
            pulses += int'(rvalid[k]) + int'(wack[k]) + int'(err[k]);
            if (kind == 0 && (rvalid[k] || wack[k] || err[k])) begin
                kind = rvalid[k] ? 1 : (wack[k] ? 2 : 3);
                lat  = j;
                data = rdata[k];
            end
            if (!rvalid[k] && rdata[k] != 32'h0) zero_viol++;
        end
    endtask

    initial begin
        int kind, lat, pulses, zv, nvalid, t1, t2, acc, quiet;
        logic [31:0] data, v0, d1, d2;
        bit will;

        vecs[0]  = mk(0, 0, 1, 9'h008, 32'hDEADBEEF, 2, 0,  32'h0);
        vecs[1]  = mk(0, 1, 1, 9'h008, 32'h0,        1, 2,  32'hDEADBEEF);
        vecs[2]  = mk(0, 1, 1, 9'h006, 32'h0,        3, 0,  32'h0);
        vecs[3]  = mk(0, 1, 1, 9'h100, 32'h0,        3, 0,  32'h0);
        vecs[4]  = mk(0, 0, 1, 9'h0FC, 32'hA5A50001, 2, 0,  32'h0);
        vecs[5]  = mk(0, 1, 1, 9'h0FC, 32'h0,        1, 2,  32'hA5A50001);
        vecs[6]  = mk(0, 0, 1, 9'h000, 32'h11111111, 2, 0,  32'h0);
        vecs[7]  = mk(0, 0, 1, 9'h004, 32'h22222222, 2, 0,  32'h0);
        vecs[8]  = mk(0, 0, 1, 9'h00C, 32'h00000077, 2, 0,  32'h0);
        vecs[9]  = mk(0, 0, 1, 9'h002, 32'h99999999, 3, 0,  32'h0);
        vecs[10] = mk(0, 1, 1, 9'h000, 32'h0,        1, 2,  32'h11111111);
        vecs[11] = mk(0, 0, 1, 9'h1FC, 32'h88888888, 3, 0,  32'h0);
        vecs[12] = mk(0, 1, 1, 9'h004, 32'h0,        1, 2,  32'h22222222);
        vecs[13] = mk(1, 0, 1, 9'h008, 32'hDEADBEEF, 2, 0,  32'h0);
        vecs[14] = mk(1, 1, 1, 9'h008, 32'h0,        1, 1,  32'hDEADBEEF);
        vecs[15] = mk(2, 0, 1, 9'h008, 32'hDEADBEEF, 2, 0,  32'h0);
        vecs[16] = mk(2, 1, 1, 9'h008, 32'h0,        1, 15, 32'hDEADBEEF);

        // Reset state
        #1 reset = 1'b1;
        #2;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset ready d%0d", k), 32'(ready[k]), 32'h1);
            chk($sformatf("reset pulses d%0d", k), 32'({rvalid[k], wack[k], err[k]}), 32'h0);
            chk($sformatf("reset rdata d%0d", k), rdata[k], 32'h0);
        end
        @(negedge clock);
        reset = 1'b0;

        // Table-driven single transactions
        for (int i = 0; i < 17; i++) begin
            run_op(vecs[i].dut, vecs[i].rd, vecs[i].sel, vecs[i].addr, vecs[i].wdata,
                   kind, lat, data, pulses, zv);
            chk($sformatf("v%0d kind", i), 32'(kind), 32'(vecs[i].exp_kind));
            chk($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("v%0d pulses", i), 32'(pulses), 32'h1);
            chk($sformatf("v%0d rdata idle zero", i), 32'(zv), 32'h0);
            if (vecs[i].exp_kind == 1)
                chk($sformatf("v%0d rdata", i), data, vecs[i].exp_data);
        end

        // Instruction bank is write-protected: value unchanged by a write attempt
        run_op(0, 1'b1, 1'b0, 9'h004, 32'h0, kind, lat, data, pulses, zv);
        chk("ibank read kind", 32'(kind), 32'h1);
        v0 = data;
        run_op(0, 1'b0, 1'b0, 9'h004, 32'h00001234, kind, lat, data, pulses, zv);
        chk("ibank write error", 32'(kind), 32'h3);
        chk("ibank write pulses", 32'(pulses), 32'h1);
        run_op(0, 1'b1, 1'b0, 9'h004, 32'h0, kind, lat, data, pulses, zv);
        chk("ibank reread data", data, v0);

        // memReq held high for two reads: the second waits for memReady
        @(negedge clock);
        rd = 1'b1; sel = 1'b1; addr = 9'h000; req[0] = 1'b1;
        acc = 0; nvalid = 0; t1 = -1; t2 = -1; d1 = '0; d2 = '0;
        for (int c = 0; c < 30; c++) begin
            will = ready[0] && req[0];
            @(posedge clock);
            #1;
            if (will) begin
                acc++;
                if (acc == 1) addr = 9'h004;
                else req[0] = 1'b0;
            end
            @(negedge clock);
            if (rvalid[0]) begin
                nvalid++;
                if (nvalid == 1) begin t1 = c; d1 = rdata[0]; end
                else begin t2 = c; d2 = rdata[0]; end
            end
        end
        req[0] = 1'b0;
        chk("b2b valid count", 32'(nvalid), 32'h2);
        chk("b2b first latency", 32'(t1), 32'h2);
        chk("b2b spacing", 32'(t2 - t1), 32'h3);
        chk("b2b data0", d1, 32'h11111111);
        chk("b2b data1", d2, 32'h22222222);

        // Reset one cycle after read acceptance aborts the read
        @(negedge clock);
        rd = 1'b1; sel = 1'b1; addr = 9'h008; req[0] = 1'b1;
        @(posedge clock);
        #1 req[0] = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("abort ready", 32'(ready[0]), 32'h1);
        chk("abort rvalid", 32'(rvalid[0]), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        quiet = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clock);
            quiet += int'(rvalid[0]) + int'(wack[0]) + int'(err[0]);
        end
        chk("abort no pulse", 32'(quiet), 32'h0);
        run_op(0, 1'b1, 1'b1, 9'h008, 32'h0, kind, lat, data, pulses, zv);
        chk("post reset read lat", 32'(lat), 32'h2);
        chk("post reset read data", data, 32'hDEADBEEF);

        // Reset during WRITE loses the write; acceptance on first edge after release
        @(negedge clock);
        rd = 1'b0; sel = 1'b1; addr = 9'h00C; wdata = 32'h55555555; req[0] = 1'b1;
        @(posedge clock);
        #1 req[0] = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("wabort wack cleared", 32'(wack[0]), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        rd = 1'b1; sel = 1'b1; addr = 9'h00C; req[0] = 1'b1;
        @(posedge clock);
        #1 req[0] = 1'b0;
        lat = -1; data = '0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clock);
            if (rvalid[0] && lat < 0) begin lat = j; data = rdata[0]; end
        end
        chk("wabort read lat", 32'(lat), 32'h2);
        chk("wabort old data", data, 32'h00000077);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
